note_judge: RTL

- Sits directly downstream of note_spawner and consumes its lane `locations` and `note_spawn` outputs together with the player's arrow buttons.
- Judges each button press against the oldest live note in its lane and grades it PERFECT or GOOD.
- Detects notes that scroll past the hit zone and counts them as MISS.
- Keeps score, combo and max-combo, and pulses `note_clear` so note_spawner retires each judged note.

---
 rtl/note_judge_pkg.sv | 27 ++
 rtl/note_judge_if.sv | 27 ++
 rtl/note_judge_lane_judge.sv | 35 +++
 rtl/note_judge.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/note_judge_pkg.sv
// Shared constants and types for the note_judge block.
// Judge result encoding and lane geometry used by the top level and lane_judge.
package note_judge_pkg;

    localparam int unsigned LANES        = 4;
    localparam int unsigned ROW_W        = 4;
    localparam int unsigned DEF_HIT_ROW  = 12;
    localparam int unsigned DEF_MISS_ROW = 14;

    typedef enum logic [1:0] {
        JudgeNone    = 2'b00,
        JudgePerfect = 2'b01,
        JudgeGood    = 2'b10,
        JudgeMiss    = 2'b11
    } judge_e;

    // Severity order for the display: MISS beats GOOD beats PERFECT.
    function automatic judge_e worst_of(input logic any_miss, input logic any_good);
        if (any_miss) begin
            return JudgeMiss;
        end else if (any_good) begin
            return JudgeGood;
        end
        return JudgePerfect;
    endfunction

endpackage

// File: rtl/note_judge_if.sv
// Lane, button and scoring signals between the player/spawner side and note_judge.
interface note_judge_if
    import note_judge_pkg::*;
;
    logic [LANES-1:0]       btn;
    logic [LANES*ROW_W-1:0] locations;
    logic [LANES-1:0]       note_spawn;
    logic                   animate;
    logic [1:0]             level_num;
    logic [LANES-1:0]       note_clear;
    logic [1:0]             judge_code;
    logic                   judge_valid;
    logic [15:0]            score;
    logic [7:0]             combo;
    logic [7:0]             max_combo;

    modport slave (
        input  btn, locations, note_spawn, animate, level_num,
        output note_clear, judge_code, judge_valid, score, combo, max_combo
    );

    modport master (
        output btn, locations, note_spawn, animate, level_num,
        input  note_clear, judge_code, judge_valid, score, combo, max_combo
    );

endinterface

// File: rtl/note_judge_lane_judge.sv
// Combinational grading of one lane: press distance to the hit row, or miss on a frame tick.
module lane_judge
    import note_judge_pkg::*;
#(
    parameter int unsigned HIT_ROW  = DEF_HIT_ROW,
    parameter int unsigned MISS_ROW = DEF_MISS_ROW
) (
    input  logic             i_press,
    input  logic [ROW_W-1:0] i_row,
    input  logic             i_valid,
    input  logic             i_tick,
    output logic             o_perfect,
    output logic             o_good,
    output logic             o_miss,
    output logic             o_clear
);

    // One extra bit so HIT_ROW-1 wraps out of the row range when HIT_ROW is 0.
    localparam logic [ROW_W:0] One    = 1;
    localparam logic [ROW_W:0] HitW   = HIT_ROW[ROW_W:0];
    localparam logic [ROW_W:0] HitLo  = HitW - One;
    localparam logic [ROW_W:0] HitHi  = HitW + One;
    localparam logic [ROW_W:0] MissW  = MISS_ROW[ROW_W:0];

    logic [ROW_W:0] w_row;
    logic           w_hit;

    assign w_row     = {1'b0, i_row};
    assign o_perfect = i_press & i_valid & (w_row == HitW);
    assign o_good    = i_press & i_valid & ((w_row == HitLo) | (w_row == HitHi));
    assign w_hit     = o_perfect | o_good;
    assign o_miss    = ~w_hit & i_tick & i_valid & (w_row >= MissW);
    assign o_clear   = w_hit | o_miss;

endmodule

// File: rtl/note_judge.sv
// Rhythm-game judge: grades presses per lane, detects misses, keeps score/combo and
// holds the latest judgement on display for a number of frame ticks.
module note_judge
    import note_judge_pkg::*;
#(
    parameter int unsigned HIT_ROW     = DEF_HIT_ROW,
    parameter int unsigned MISS_ROW    = DEF_MISS_ROW,
    parameter int unsigned PERFECT_PTS = 10,
    parameter int unsigned GOOD_PTS    = 5,
    parameter int unsigned HOLD_FRAMES = 8
) (
    input logic         clk,
    input logic         rst_n,
    note_judge_if.slave bus
);

    localparam int unsigned CntW   = $clog2(HOLD_FRAMES + 1);
    localparam int unsigned CountW = $clog2(LANES + 1);

    logic [LANES-1:0]  r_btn_q;
    logic              r_animate_q;
    logic [LANES-1:0]  r_clear;
    judge_e            r_code;
    logic              r_valid;
    logic [15:0]       r_score;
    logic [7:0]        r_combo;
    logic [7:0]        r_max;
    logic [CntW-1:0]   r_hold;

    logic [LANES-1:0]  w_press;
    logic              w_tick;
    logic [LANES-1:0]  w_perfect;
    logic [LANES-1:0]  w_good;
    logic [LANES-1:0]  w_miss;
    logic [LANES-1:0]  w_clear;
    logic [CountW-1:0] w_n_perfect;
    logic [CountW-1:0] w_n_good;
    logic [17:0]       w_pts;
    logic [17:0]       w_score_sum;
    logic [15:0]       w_score_d;
    logic [8:0]        w_combo_sum;
    logic [7:0]        w_combo_d;
    logic [7:0]        w_max_d;
    judge_e            w_code_d;
    logic [CntW-1:0]   w_hold_d;

    assign w_press = bus.btn & ~r_btn_q;
    assign w_tick  = bus.animate & ~r_animate_q;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        lane_judge #(
            .HIT_ROW  (HIT_ROW),
            .MISS_ROW (MISS_ROW)
        ) u_lane (
            .i_press   (w_press[gi]),
            .i_row     (bus.locations[gi*ROW_W +: ROW_W]),
            .i_valid   (bus.note_spawn[gi]),
            .i_tick    (w_tick),
            .o_perfect (w_perfect[gi]),
            .o_good    (w_good[gi]),
            .o_miss    (w_miss[gi]),
            .o_clear   (w_clear[gi])
        );
    end

    always_comb begin
        w_n_perfect = '0;
        w_n_good    = '0;
        for (int i = 0; i < LANES; i++) begin
            w_n_perfect = w_n_perfect + CountW'(w_perfect[i]);
            w_n_good    = w_n_good + CountW'(w_good[i]);
        end
    end

    // Score sum is kept 18 bits wide so an overflow past 16'hFFFF is visible before clamping.
    always_comb begin
        w_pts = (18'(w_n_perfect) * 18'(PERFECT_PTS) + 18'(w_n_good) * 18'(GOOD_PTS))
                * (18'(bus.level_num) + 18'd1);
        w_score_sum = {2'b00, r_score} + w_pts;
        w_score_d   = (w_score_sum > 18'h0FFFF) ? 16'hFFFF : w_score_sum[15:0];
    end

    always_comb begin
        w_combo_sum = {1'b0, r_combo} + 9'(w_n_perfect) + 9'(w_n_good);
        if (|w_miss) begin
            w_combo_d = 8'd0;
        end else if (w_combo_sum > 9'd255) begin
            w_combo_d = 8'hFF;
        end else begin
            w_combo_d = w_combo_sum[7:0];
        end
        w_max_d = (w_combo_d > r_max) ? w_combo_d : r_max;
    end

    always_comb begin
        w_code_d = r_code;
        w_hold_d = r_hold;
        if (|w_clear) begin
            w_code_d = worst_of(|w_miss, |w_good);
            w_hold_d = CntW'(HOLD_FRAMES);
        end else if (w_tick && (r_hold != '0)) begin
            w_hold_d = r_hold - CntW'(1);
            if (r_hold == CntW'(1)) begin
                w_code_d = JudgeNone;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_q     <= '0;
            r_animate_q <= 1'b0;
            r_clear     <= '0;
            r_code      <= JudgeNone;
            r_valid     <= 1'b0;
            r_score     <= '0;
            r_combo     <= '0;
            r_max       <= '0;
            r_hold      <= '0;
        end else begin
            r_btn_q     <= bus.btn;
            r_animate_q <= bus.animate;
            r_clear     <= w_clear;
            r_code      <= w_code_d;
            r_valid     <= |w_clear;
            r_score     <= w_score_d;
            r_combo     <= w_combo_d;
            r_max       <= w_max_d;
            r_hold      <= w_hold_d;
        end
    end

    assign bus.note_clear  = r_clear;
    assign bus.judge_code  = r_code;
    assign bus.judge_valid = r_valid;
    assign bus.score       = r_score;
    assign bus.combo       = r_combo;
    assign bus.max_combo   = r_max;

endmodule
